lsu_mem_arb: RTL and testbench
==============================

# lsu_mem_arb

Load/store access controller and two-port arbiter in front of the word-wide data memory. It accepts byte/halfword/word load and store requests from the core (port 0) and the debug/loader port (port 1), and grants them round-robin. Sub-word stores are performed as read-modify-write sequences, and load data is extracted and extended to 32 bits. It sits between the load/store stage and the synchronous single-port data SRAM, which has no byte enables.

## Interface
- AW, 16, byte address width; memory word address is AW-2 bits

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  request present (N = 0 core, 1 debug)
- reqN_ready  out  1  request accepted this cycle
- reqN_wr_en  in  1  1 = store, 0 = load
- reqN_slt_sl  in  3  access size code: SB 000, SH 001, SW 010, LB 011, LH 100, LW 101, LBU 110, LHU 111
- reqN_addr  in  AW  byte address
- reqN_wdata  in  32  store data, right-aligned
- rspN_valid  out  1  one-cycle response pulse
- rspN_rdata  out  32  load result; 0 for stores and errors
- rspN_err  out  1  misaligned access, qualified by rspN_valid
- mem_addr  out  AW-2  word address
- mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle
- mem_wr_en  out  1  full-word write strobe
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RD, WAIT, WR, RESP. One request is in flight at a time.
- IDLE arbitration:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the port named by the priority pointer.
  - reqN_ready is high combinationally for the granted port in IDLE only.
  - On acceptance, latch wr_en, slt_sl, addr, wdata and the port ID. The pointer moves to the non-granted port.
- Requesters hold valid and all fields stable until ready is high. A request is captured only at acceptance.
- Misaligned access: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0. Sequence is IDLE→RESP with err=1. No memory strobe is issued.
- wr_en and slt_sl disagreeing (e.g. wr_en=1 with a load code) is also an error; handle it as misaligned.
- SW: IDLE→WR→RESP. WR writes wdata to addr[AW-1:2].
- SB/SH: IDLE→RD→WAIT→WR→RESP.
  - WAIT captures mem_rdata.
  - Merge for SB: byte lane addr[1:0] gets wdata[7:0].
  - Merge for SH: halfword addr[1] gets wdata[15:0].
  - All other bytes are preserved. WR writes the merged word.
- Loads: IDLE→RD→WAIT→RESP. WAIT extracts the addressed byte or halfword, shifts it to bit 0, and registers the result:
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: full word.
- RESP pulses rspN_valid for the latched port only, then returns to IDLE.
- mem_addr is driven from the latched address in RD and WR, and is 0 otherwise.

## Timing
- Reset state: FSM in IDLE, priority pointer = port 0. All outputs 0 (ready, rsp_valid, rsp_rdata, rsp_err, mem strobes, mem_addr, mem_wdata, busy).
- Latency from acceptance cycle T to rspN_valid:
  - Error: T+1.
  - SW: T+2; mem_wr_en at T+1.
  - Load: T+3; mem_rd_en at T+1.
  - SB/SH: T+4; mem_rd_en at T+1, mem_wr_en at T+3.
- Next acceptance happens no earlier than the cycle after RESP.
- A request arriving while busy waits with ready=0; it is never dropped.
- Reset mid-operation takes priority over everything:
  - FSM returns to IDLE and no response is issued.
  - If reset is asserted in RD or WAIT of a sub-word store, the memory write never occurs.
- rspN_rdata and rspN_err are held at 0 outside RESP.

## Test plan
- Preload word 0x4 = 0x8899AABB. Port 0 LW addr 0x0010 accepted at T → mem_rd_en at T+1; rsp0_valid at T+3 with rdata 0x8899AABB, err 0.
- Port 0 SB addr 0x0011, wdata 0x000000CC → mem_wr_en at T+3 with mem_wdata 0x8899CCBB; rsp0 at T+4. Then LB 0x0011 → 0xFFFFFFCC, and LBU 0x0011 → 0x000000CC.
- Port 1 SH addr 0x0012, wdata 0x00001234 → word becomes 0x1234CCBB, rsp1 at T+4. Then LH 0x0012 → 0x00001234. Then SH 0x0012 wdata 0xF00D followed by LH → 0xFFFFF00D, and LHU → 0x0000F00D.
- Port 0 LW addr 0x0011 → rsp0 at T+1 with err 1 and rdata 0; no mem_rd_en or mem_wr_en at any cycle.
- After reset, both ports continuously request SW → grants alternate port 0, 1, 0, 1. Each accept is 3 cycles apart, and no response goes to the wrong port.
- Pulse rst during WAIT of SB addr 0x0013 → no mem_wr_en, no rsp, busy 0 the next cycle, memory word unchanged, pointer back to port 0.

Source files
------------

// File: rtl/lsu_mem_arb.sv
// Load/store controller and round-robin two-port arbiter for a word SRAM.
// Ports: req0/req1 request in, rsp0/rsp1 response out, mem_* SRAM side, busy.
module lsu_mem_arb #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_wr_en,
  input  logic [2:0]    req0_slt_sl,
  input  logic [AW-1:0] req0_addr,
  input  logic [31:0]   req0_wdata,
  output logic          rsp0_valid,
  output logic [31:0]   rsp0_rdata,
  output logic          rsp0_err,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_wr_en,
  input  logic [2:0]    req1_slt_sl,
  input  logic [AW-1:0] req1_addr,
  input  logic [31:0]   req1_wdata,
  output logic          rsp1_valid,
  output logic [31:0]   rsp1_rdata,
  output logic          rsp1_err,
  output logic [AW-3:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] LH  = 3'b100;
  localparam logic [2:0] LW  = 3'b101;
  localparam logic [2:0] LBU = 3'b110;
  localparam logic [2:0] LHU = 3'b111;

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, WR, RESP
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          port_q, port_d;
  logic          wr_q, wr_d;
  logic [2:0]    slt_q, slt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-3:0] maddr_q, maddr_d;
  logic          mrd_q, mrd_d;
  logic          mwr_q, mwr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  // Misaligned sizes and wr_en/size disagreement both end as errors.
  function automatic logic bad_req(
    input logic       wr,
    input logic [2:0] slt,
    input logic [1:0] a
  );
    logic mis;
    mis = 1'b0;
    unique case (slt)
      SH, LH, LHU: mis = a[0];
      SW, LW:      mis = |a;
      default:     mis = 1'b0;
    endcase
    return mis | (wr != (slt <= SW));
  endfunction

  function automatic logic [31:0] ext(
    input logic [2:0]  slt,
    input logic [1:0]  a,
    input logic [31:0] w
  );
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] r;
    b = w >> {a, 3'b000};
    h = w >> {a[1], 4'b0000};
    unique case (slt)
      LB:      r = {{24{b[7]}}, b[7:0]};
      LBU:     r = {24'h0, b[7:0]};
      LH:      r = {{16{h[15]}}, h[15:0]};
      LHU:     r = {16'h0, h[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // SRAM has no byte enables: splice the new lane into the old word.
  function automatic logic [31:0] merge(
    input logic [2:0]  slt,
    input logic [1:0]  a,
    input logic [31:0] old,
    input logic [31:0] wd
  );
    logic [4:0]  sh;
    logic [31:0] m;
    logic [31:0] d;
    if (slt == SB) begin
      sh = {a, 3'b000};
      m  = 32'h0000_00ff << sh;
      d  = (wd & 32'h0000_00ff) << sh;
    end else begin
      sh = {a[1], 4'b0000};
      m  = 32'h0000_ffff << sh;
      d  = (wd & 32'h0000_ffff) << sh;
    end
    return (old & ~m) | d;
  endfunction

  logic          any_v;
  logic          gnt;
  logic          idle;
  logic          s_wr;
  logic [2:0]    s_slt;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;

  assign idle  = (state_q == IDLE);
  assign any_v = req0_valid | req1_valid;
  // Pointer only matters on contention.
  assign gnt   = (req0_valid & req1_valid) ? ptr_q
                                           : req1_valid;

  assign req0_ready = idle & any_v & ~gnt;
  assign req1_ready = idle & any_v & gnt;

  assign s_wr    = gnt ? req1_wr_en  : req0_wr_en;
  assign s_slt   = gnt ? req1_slt_sl : req0_slt_sl;
  assign s_addr  = gnt ? req1_addr   : req0_addr;
  assign s_wdata = gnt ? req1_wdata  : req0_wdata;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    port_d   = port_q;
    wr_d     = wr_q;
    slt_d    = slt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    maddr_d  = '0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    mwdata_d = '0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    rerr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          port_d  = gnt;
          ptr_d   = ~gnt;
          wr_d    = s_wr;
          slt_d   = s_slt;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          if (bad_req(s_wr, s_slt, s_addr[1:0])) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
          end else if (s_slt == SW) begin
            state_d  = WR;
            mwr_d    = 1'b1;
            maddr_d  = s_addr[AW-1:2];
            mwdata_d = s_wdata;
          end else begin
            state_d = RD;
            mrd_d   = 1'b1;
            maddr_d = s_addr[AW-1:2];
          end
        end
      end
      RD: state_d = WAIT;
      WAIT: begin
        if (wr_q) begin
          state_d  = WR;
          mwr_d    = 1'b1;
          maddr_d  = addr_q[AW-1:2];
          mwdata_d = merge(slt_q, addr_q[1:0],
                           mem_rdata, wdata_q);
        end else begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = ext(slt_q, addr_q[1:0], mem_rdata);
        end
      end
      WR: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      port_q   <= 1'b0;
      wr_q     <= 1'b0;
      slt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      maddr_q  <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      mwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      port_q   <= port_d;
      wr_q     <= wr_d;
      slt_q    <= slt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      mwdata_q <= mwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign mem_addr  = maddr_q;
  assign mem_rd_en = mrd_q;
  assign mem_wr_en = mwr_q;
  assign mem_wdata = mwdata_q;
  assign busy      = ~idle;

  assign rsp0_valid = rvalid_q & ~port_q;
  assign rsp1_valid = rvalid_q & port_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
  assign rsp0_err   = rsp0_valid & rerr_q;
  assign rsp1_err   = rsp1_valid & rerr_q;

endmodule

// File: tb/tb_lsu_mem_arb.sv
// Scoreboard bench for lsu_mem_arb with a behavioural word SRAM.
// Directed vectors; monitor checks responses and SRAM strobes.
module tb_lsu_mem_arb;
  localparam int AW = 16;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] LH  = 3'b100;
  localparam logic [2:0] LW  = 3'b101;
  localparam logic [2:0] LBU = 3'b110;
  localparam logic [2:0] LHU = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v  [2];
  logic          w  [2];
  logic [2:0]    s  [2];
  logic [AW-1:0] ad [2];
  logic [31:0]   d  [2];

  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [31:0]   rsp0_rdata, rsp1_rdata;
  logic          rsp0_err, rsp1_err;
  logic [AW-3:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  lsu_mem_arb #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready),
    .req0_wr_en(w[0]), .req0_slt_sl(s[0]),
    .req0_addr(ad[0]), .req0_wdata(d[0]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(v[1]), .req1_ready(req1_ready),
    .req1_wr_en(w[1]), .req1_slt_sl(s[1]),
    .req1_addr(ad[1]), .req1_wdata(d[1]),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[9:0]];
    if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [31:0] wdata;
  } mx_t;

  rsp_t q0[$];
  rsp_t q1[$];
  mx_t  rdq[$];
  mx_t  wrq[$];
  int   accp[$];
  int   acct[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin : mon
    rsp_t e;
    mx_t  m;
    if (!rst) begin
      if (rsp0_valid) begin
        if (q0.size() == 0) flag("rsp0_unexpected");
        else begin
          e = q0.pop_front();
          chk("rsp0_rdata", rsp0_rdata, e.rdata);
          chk("rsp0_err", rsp0_err, e.err);
          chk("rsp0_cycle", cyc, e.cyc);
        end
      end
      if (rsp1_valid) begin
        if (q1.size() == 0) flag("rsp1_unexpected");
        else begin
          e = q1.pop_front();
          chk("rsp1_rdata", rsp1_rdata, e.rdata);
          chk("rsp1_err", rsp1_err, e.err);
          chk("rsp1_cycle", cyc, e.cyc);
        end
      end
      if (mem_rd_en) begin
        if (rdq.size() == 0) flag("mem_rd_unexpected");
        else begin
          m = rdq.pop_front();
          chk("mem_rd_cycle", cyc, m.cyc);
          chk("mem_rd_addr", mem_addr, m.addr);
        end
      end
      if (mem_wr_en) begin
        if (wrq.size() == 0) flag("mem_wr_unexpected");
        else begin
          m = wrq.pop_front();
          chk("mem_wr_cycle", cyc, m.cyc);
          chk("mem_wr_addr", mem_addr, m.addr);
          chk("mem_wr_data", mem_wdata, m.wdata);
        end
      end
    end
  end

  task automatic issue(
    input int          p,
    input logic        wr,
    input logic [2:0]  slt,
    input logic [15:0] a,
    input logic [31:0] wd,
    input logic [31:0] er,
    input logic        ee,
    input int          lat,
    input logic        ers,
    input logic        erd,
    input logic        ewr,
    input logic [31:0] ewd
  );
    int   t;
    bit   ok;
    rsp_t e;
    mx_t  m;
    ok = 0;
    @(negedge clk);
    v[p] = 1'b1;
    w[p] = wr;
    s[p] = slt;
    ad[p] = a;
    d[p] = wd;
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((p == 0) ? req0_ready : req1_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      flag("accept_timeout");
      v[p] = 1'b0;
      return;
    end
    t = cyc;
    accp.push_back(p);
    acct.push_back(t);
    if (ers) begin
      e.rdata = er;
      e.err = ee;
      e.cyc = t + lat;
      if (p == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    if (erd) begin
      m.cyc = t + 1;
      m.addr = a[15:2];
      m.wdata = '0;
      rdq.push_back(m);
    end
    if (ewr) begin
      m.cyc = t + lat - 1;
      m.addr = a[15:2];
      m.wdata = ewd;
      wrq.push_back(m);
    end
    @(posedge clk);
    #1;
    v[p] = 1'b0;
  endtask

  task automatic ld(input int p, input logic [2:0] slt,
                    input logic [15:0] a,
                    input logic [31:0] er);
    issue(p, 1'b0, slt, a, 32'h0, er, 1'b0, 3,
          1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic stsub(input int p, input logic [2:0] slt,
                       input logic [15:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] ewd);
    issue(p, 1'b1, slt, a, wd, 32'h0, 1'b0, 4,
          1'b1, 1'b1, 1'b1, ewd);
  endtask

  task automatic stw(input int p, input logic [15:0] a,
                     input logic [31:0] wd);
    issue(p, 1'b1, SW, a, wd, 32'h0, 1'b0, 2,
          1'b1, 1'b0, 1'b1, wd);
  endtask

  task automatic bad(input int p, input logic wr,
                     input logic [2:0] slt,
                     input logic [15:0] a);
    issue(p, wr, slt, a, 32'hffff_ffff, 32'h0, 1'b1, 1,
          1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q0.size() + q1.size() + rdq.size()
          + wrq.size() == 0) break;
      @(negedge clk);
    end
    if (q0.size() + q1.size() + rdq.size()
        + wrq.size() != 0) begin
      flag("drain_pending");
      q0.delete();
      q1.delete();
      rdq.delete();
      wrq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0;
      w[i] = 1'b0;
      s[i] = '0;
      ad[i] = '0;
      d[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
         rsp0_err, rsp1_err, mem_rd_en, mem_wr_en, busy},
        9'h0);
    chk("reset_data", {rsp0_rdata, rsp1_rdata}, 64'h0);
    chk("reset_mem", {mem_addr, mem_wdata}, 46'h0);
    rst = 1'b0;

    stw(1, 16'h0010, 32'h8899_aabb);
    ld(0, LW, 16'h0010, 32'h8899_aabb);
    stsub(0, SB, 16'h0011, 32'h0000_00cc, 32'h8899_ccbb);
    ld(0, LB, 16'h0011, 32'hffff_ffcc);
    ld(0, LBU, 16'h0011, 32'h0000_00cc);
    stsub(1, SH, 16'h0012, 32'h0000_1234, 32'h1234_ccbb);
    ld(1, LH, 16'h0012, 32'h0000_1234);
    stsub(1, SH, 16'h0012, 32'h0000_f00d, 32'hf00d_ccbb);
    ld(1, LH, 16'h0012, 32'hffff_f00d);
    ld(1, LHU, 16'h0012, 32'h0000_f00d);
    bad(0, 1'b0, LW, 16'h0011);
    bad(1, 1'b1, SH, 16'h0013);
    bad(0, 1'b1, LW, 16'h0010);
    bad(1, 1'b0, SB, 16'h0010);
    ld(0, LB, 16'h0010, 32'hffff_ffbb);
    ld(1, LBU, 16'h0013, 32'h0000_00f0);
    stw(0, 16'h0020, 32'hdead_beef);
    ld(1, LW, 16'h0020, 32'hdead_beef);
    drain();

    // Reset during WAIT of an SB: no write, no response.
    issue(0, 1'b1, SB, 16'h0013, 32'h0000_0055, 32'h0,
          1'b0, 4, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wait", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    chk("rst_no_wr", mem_wr_en, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_word", mem[4], 32'hf00d_ccbb);
    drain();

    accp.delete();
    acct.delete();
    fork
      for (int i = 0; i < 3; i++)
        stw(0, 16'h0040 + 16'(4 * i), 32'ha000_0000 + i);
      for (int j = 0; j < 3; j++)
        stw(1, 16'h0080 + 16'(4 * j), 32'hb000_0000 + j);
    join
    drain();
    chk("rr_accepts", accp.size(), 6);
    for (int k = 0; k < accp.size(); k++) begin
      chk("rr_port", accp[k], k % 2);
      if (k > 0) chk("rr_spacing", acct[k] - acct[k-1], 3);
    end
    chk("rr_mem_p0", mem[16'h0048 >> 2], 32'ha000_0002);
    chk("rr_mem_p1", mem[16'h0084 >> 2], 32'hb000_0001);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
